// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction-fetch stage of the five-stage WISC pipeline.
//
// Owns the PC, drives the instruction-cache read port and produces the IF/ID
// pipeline register (instruction, PC+2, valid) consumed by decode. Handles
// cache-miss waits, branch redirects (including redirects that arrive while a
// miss is outstanding), load-use stalls and the terminal HLT state.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   branch_taken        decode resolved a taken branch (single-cycle pulse)
//   branch_target[15:0] redirect address, valid with branch_taken
//   hazard_stall        hold PC, IF/ID and redirect register
//   icache_ready        icache_instr valid for icache_addr this cycle
//   icache_instr[15:0]  instruction word from the cache
//   icache_addr[15:0]   fetch address (PC register)
//   icache_req          read request
//   IFID_instr[15:0]    registered instruction to decode
//   IFID_PC_two[15:0]   registered PC+2 of IFID_instr
//   IFID_valid          IF/ID holds a real instruction
//   halted              fetch stopped on HLT
//   perf_fetch_cnt      (FETCH_PERF_CNT_EN) cycles loading IFID_valid=1
//   perf_stall_cnt      (FETCH_PERF_CNT_EN) cycles in MISS_WAIT/REDIR_WAIT
//   dbg_state_o[1:0]    current FSM state for debug/checkers
//
// Handshake: the cache port is a level request; icache_req high with
// icache_addr stable means "read this address", and the word is consumed on
// the rising edge where icache_ready is high. The address only changes after
// an edge on which icache_ready was seen (or on a branch outside a miss).
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE   = 4'hF,
  parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        hazard_stall,
  input  logic        icache_ready,
  input  logic [15:0] icache_instr,
  output logic [15:0] icache_addr,
  output logic        icache_req,
  output logic [15:0] IFID_instr,
  output logic [15:0] IFID_PC_two,
  output logic        IFID_valid,
  output logic        halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_stall_cnt,
`endif
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MISS_WAIT  = 2'd1,
    ST_REDIR_WAIT = 2'd2,
    ST_HALT       = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] redir_q, redir_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_two_q, pc_two_d;
  logic        valid_q, valid_d;
  logic        capture;
  logic [15:0] pc_plus2;
  logic [15:0] redir_tgt;
  logic        is_hlt;

  assign pc_plus2 = pc_q + 16'd2;  // wraps modulo 2^16
  assign is_hlt   = (icache_instr[15:12] == HLT_OPCODE);
  // A branch seen while already waiting on a redirect replaces the target.
  assign redir_tgt = branch_taken ? branch_target : redir_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redir_d  = redir_q;
    instr_d  = instr_q;
    pc_two_d = pc_two_q;
    valid_d  = valid_q;
    capture  = 1'b0;

    unique case (state_q)
      ST_RUN, ST_MISS_WAIT: begin
        if (branch_taken) begin
          instr_d = BUBBLE_INSTR;
          valid_d = 1'b0;
          if (state_q == ST_MISS_WAIT && !icache_ready) begin
            // Cache still busy with the wrong-path line: park the target
            // and keep the old address on the port until the fill ends.
            redir_d = branch_target;
            state_d = ST_REDIR_WAIT;
          end else begin
            pc_d    = branch_target;
            state_d = ST_RUN;
          end
        end else if (hazard_stall) begin
          // Nothing is captured, but miss tracking still follows the cache.
          state_d = icache_ready ? ST_RUN : ST_MISS_WAIT;
        end else if (icache_ready) begin
          capture  = 1'b1;
          instr_d  = icache_instr;
          pc_two_d = pc_plus2;
          valid_d  = 1'b1;
          if (is_hlt) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_plus2;
            state_d = ST_RUN;
          end
        end else begin
          instr_d = BUBBLE_INSTR;
          valid_d = 1'b0;
          state_d = ST_MISS_WAIT;
        end
      end

      ST_REDIR_WAIT: begin
        if (branch_taken || !hazard_stall) begin
          instr_d = BUBBLE_INSTR;
          valid_d = 1'b0;
        end
        if (icache_ready) begin
          // Fill finished: the returned word is wrong-path and discarded.
          // The PC load is part of leaving this state, so it is not held
          // back by a stall; IF/ID only ever holds a bubble here anyway.
          pc_d    = redir_tgt;
          state_d = ST_RUN;
        end else if (branch_taken || !hazard_stall) begin
          redir_d = redir_tgt;
        end
      end

      ST_HALT: begin
        instr_d = BUBBLE_INSTR;
        valid_d = 1'b0;
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      redir_q  <= 16'h0000;
      instr_q  <= BUBBLE_INSTR;
      pc_two_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      redir_q  <= redir_d;
      instr_q  <= instr_d;
      pc_two_q <= pc_two_d;
      valid_q  <= valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;
  logic        in_wait;

  assign in_wait = (state_q == ST_MISS_WAIT) || (state_q == ST_REDIR_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      if (capture && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (in_wait && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

  assign icache_addr = pc_q;
  assign icache_req  = !rst && (state_q != ST_HALT);
  assign IFID_instr  = instr_q;
  assign IFID_PC_two = pc_two_q;
  assign IFID_valid  = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage.
// Each cycle record carries the inputs for one rising edge and the outputs
// expected just after it. Expected outputs are queued when the inputs are
// driven and popped/compared #1 after the edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int W = 53;
  localparam logic [1:0] S_RUN = 2'd0, S_MISS = 2'd1, S_REDIR = 2'd2, S_HALT = 2'd3;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        hazard_stall;
  logic        icache_ready;
  logic [15:0] icache_instr;
  logic [15:0] icache_addr;
  logic        icache_req;
  logic [15:0] IFID_instr;
  logic [15:0] IFID_PC_two;
  logic        IFID_valid;
  logic        halted;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .hazard_stall  (hazard_stall),
    .icache_ready  (icache_ready),
    .icache_instr  (icache_instr),
    .icache_addr   (icache_addr),
    .icache_req    (icache_req),
    .IFID_instr    (IFID_instr),
    .IFID_PC_two   (IFID_PC_two),
    .IFID_valid    (IFID_valid),
    .halted        (halted),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .dbg_state_o   (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        br;
    logic [15:0] tgt;
    logic        stall;
    logic        rdy;
    logic [15:0] instr;
    logic [15:0] e_instr;
    logic [15:0] e_pc_two;
    logic        e_valid;
    logic [15:0] e_addr;
    logic        e_req;
    logic        e_halt;
    logic [1:0]  e_state;
  } vec_t;

  vec_t        vecs[$];
  logic [W-1:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  function automatic vec_t mk(input logic r, input logic b, input logic [15:0] t,
                              input logic s, input logic y, input logic [15:0] i,
                              input logic [15:0] ei, input logic [15:0] ep,
                              input logic ev, input logic [15:0] ea,
                              input logic eq, input logic eh, input logic [1:0] es);
    vec_t v;
    v.rst = r; v.br = b; v.tgt = t; v.stall = s; v.rdy = y; v.instr = i;
    v.e_instr = ei; v.e_pc_two = ep; v.e_valid = ev; v.e_addr = ea;
    v.e_req = eq; v.e_halt = eh; v.e_state = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // driver: apply one record, queue its expectation, compare after the edge
  task automatic step(input vec_t v);
    logic [W-1:0] e;
    rst           = v.rst;
    branch_taken  = v.br;
    branch_target = v.tgt;
    hazard_stall  = v.stall;
    icache_ready  = v.rdy;
    icache_instr  = v.instr;
    exp_q.push_back({v.e_instr, v.e_pc_two, v.e_valid, v.e_addr, v.e_req, v.e_halt, v.e_state});
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    chk("IFID_instr", IFID_instr, e[52:37]);
    if (e[20]) chk("IFID_PC_two", IFID_PC_two, e[36:21]);
    chk("IFID_valid", {15'd0, IFID_valid}, {15'd0, e[20]});
    chk("icache_addr", icache_addr, e[19:4]);
    chk("icache_req", {15'd0, icache_req}, {15'd0, e[3]});
    chk("halted", {15'd0, halted}, {15'd0, e[2]});
    chk("state", {14'd0, dbg_state}, {14'd0, e[1:0]});
  endtask

  // (rst, br, tgt, stall, rdy, instr) -> (instr, pc_two, valid, addr, req, halt, state)
  task automatic hit(input logic [15:0] w, input logic [15:0] pc_two);
    step(mk(0, 0, 16'h0, 0, 1, w, w, pc_two, 1, pc_two, 1, 0, S_RUN));
  endtask

  task automatic run_table();
    // reset state
    vecs.push_back(mk(1, 0, 16'h0, 0, 0, 16'h0, 16'h0000, 16'h0, 0, 16'h0000, 0, 0, S_RUN));
    vecs.push_back(mk(1, 0, 16'h0, 0, 1, 16'hF000, 16'h0000, 16'h0, 0, 16'h0000, 0, 0, S_RUN));
    // four hits
    vecs.push_back(mk(0, 0, 16'h0, 0, 1, 16'h1111, 16'h1111, 16'h0002, 1, 16'h0002, 1, 0, S_RUN));
    vecs.push_back(mk(0, 0, 16'h0, 0, 1, 16'h2222, 16'h2222, 16'h0004, 1, 16'h0004, 1, 0, S_RUN));
    vecs.push_back(mk(0, 0, 16'h0, 0, 1, 16'h3333, 16'h3333, 16'h0006, 1, 16'h0006, 1, 0, S_RUN));
    vecs.push_back(mk(0, 0, 16'h0, 0, 1, 16'h4444, 16'h4444, 16'h0008, 1, 16'h0008, 1, 0, S_RUN));
    // branch at 0x0008 to 0x0040: one bubble, then target fetched
    vecs.push_back(mk(0, 1, 16'h0040, 0, 1, 16'h5555, 16'h0000, 16'h0, 0, 16'h0040, 1, 0, S_RUN));
    vecs.push_back(mk(0, 0, 16'h0, 0, 1, 16'h6666, 16'h6666, 16'h0042, 1, 16'h0042, 1, 0, S_RUN));
    // branch (with stall, branch wins) squashing a wrong-path HLT, to 0x0010
    vecs.push_back(mk(0, 1, 16'h0010, 1, 1, 16'hF000, 16'h0000, 16'h0, 0, 16'h0010, 1, 0, S_RUN));
    // three-cycle miss at 0x0010
    vecs.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0BAD, 16'h0000, 16'h0, 0, 16'h0010, 1, 0, S_MISS));
    vecs.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0BAD, 16'h0000, 16'h0, 0, 16'h0010, 1, 0, S_MISS));
    vecs.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0BAD, 16'h0000, 16'h0, 0, 16'h0010, 1, 0, S_MISS));
    vecs.push_back(mk(0, 0, 16'h0, 0, 1, 16'h7777, 16'h7777, 16'h0012, 1, 16'h0012, 1, 0, S_RUN));
    foreach (vecs[i]) step(vecs[i]);
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; branch_target = 16'h0;
    hazard_stall = 1'b0; icache_ready = 1'b0; icache_instr = 16'h0;

    run_table();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_cnt", perf_stall_cnt, 16'd3);
    chk("perf_fetch_cnt", perf_fetch_cnt, 16'd6);
`endif

    // redirect during a miss at 0x0020, fill two cycles later
    step(mk(0, 1, 16'h0020, 0, 1, 16'h1234, 16'h0000, 16'h0, 0, 16'h0020, 1, 0, S_RUN));
    step(mk(0, 0, 16'h0, 0, 0, 16'h0BAD, 16'h0000, 16'h0, 0, 16'h0020, 1, 0, S_MISS));
    step(mk(0, 1, 16'h0080, 0, 0, 16'h0BAD, 16'h0000, 16'h0, 0, 16'h0020, 1, 0, S_REDIR));
    step(mk(0, 0, 16'h0, 0, 0, 16'h0BAD, 16'h0000, 16'h0, 0, 16'h0020, 1, 0, S_REDIR));
    step(mk(0, 0, 16'h0, 0, 1, 16'h9999, 16'h0000, 16'h0, 0, 16'h0080, 1, 0, S_RUN));
    hit(16'hAAAA, 16'h0082);

    // HLT at 0x000C
    step(mk(0, 1, 16'h000C, 0, 1, 16'h0BAD, 16'h0000, 16'h0, 0, 16'h000C, 1, 0, S_RUN));
    step(mk(0, 0, 16'h0, 0, 1, 16'hF000, 16'hF000, 16'h000E, 1, 16'h000C, 0, 1, S_HALT));
    step(mk(0, 1, 16'h0040, 0, 1, 16'h1111, 16'h0000, 16'h0, 0, 16'h000C, 0, 1, S_HALT));
    step(mk(0, 0, 16'h0, 1, 1, 16'h2222, 16'h0000, 16'h0, 0, 16'h000C, 0, 1, S_HALT));
    step(mk(0, 0, 16'h0, 0, 0, 16'h3333, 16'h0000, 16'h0, 0, 16'h000C, 0, 1, S_HALT));
    // reset out of HALT
    step(mk(1, 0, 16'h0, 0, 1, 16'h0, 16'h0000, 16'h0, 0, 16'h0000, 0, 0, S_RUN));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt_rst", perf_fetch_cnt, 16'd0);
    chk("perf_stall_cnt_rst", perf_stall_cnt, 16'd0);
`endif

    // PC to 0xFFFE, wrapping hit, then two stall cycles
    step(mk(0, 1, 16'hFFFE, 0, 1, 16'h0BAD, 16'h0000, 16'h0, 0, 16'hFFFE, 1, 0, S_RUN));
    hit(16'h1234, 16'h0000);
    step(mk(0, 0, 16'h0, 1, 1, 16'h5678, 16'h1234, 16'h0000, 1, 16'h0000, 1, 0, S_RUN));
    step(mk(0, 0, 16'h0, 1, 1, 16'h5678, 16'h1234, 16'h0000, 1, 16'h0000, 1, 0, S_RUN));
    hit(16'h5678, 16'h0002);

    // stall during a miss: IF/ID holds, state still tracks the cache
    step(mk(0, 0, 16'h0, 1, 0, 16'h0BAD, 16'h5678, 16'h0002, 1, 16'h0002, 1, 0, S_MISS));
    step(mk(0, 0, 16'h0, 1, 1, 16'hABCD, 16'h5678, 16'h0002, 1, 16'h0002, 1, 0, S_RUN));

    // reset while in REDIR_WAIT drops the pending redirect
    step(mk(0, 0, 16'h0, 0, 0, 16'h0BAD, 16'h0000, 16'h0, 0, 16'h0002, 1, 0, S_MISS));
    step(mk(0, 1, 16'h0100, 0, 0, 16'h0BAD, 16'h0000, 16'h0, 0, 16'h0002, 1, 0, S_REDIR));
    step(mk(1, 0, 16'h0, 0, 0, 16'h0BAD, 16'h0000, 16'h0, 0, 16'h0000, 0, 0, S_RUN));
    hit(16'h2222, 16'h0002);

    // randomised back-to-back hits from a fixed point
    begin
      logic [15:0] pc;
      logic [15:0] w;
      pc = 16'h0002;
      for (int i = 0; i < 8; i++) begin
        w  = 16'($urandom_range(0, 16'hEFFF));
        pc = pc + 16'd2;
        hit(w, pc);
      end
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations left", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
